tmem_bus: RTL and testbench

Parametrised tagged main-memory block for the micro-BESM CPU bus. It is the configurable successor to the fixed 1 Mword × 64-bit tagged RAM used by the CPU bench.
- Word width, tag width, depth and read latency are parameters.
- It adds a pipelined read path with a valid strobe, an atomic read-modify-write lock state machine and protocol-error reporting.
- It sits between the CPU bus outputs (`o_ad`, `o_tag`, `o_astb`, `o_atomic`, `o_rd`, `o_wr`) and the CPU data inputs.

---
 rtl/tmem_bus.sv | 156 +++++++++++++++
 tb/tb_tmem_bus.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmem_bus.sv
// tmem_bus: parametrised tagged main memory for the micro-BESM CPU bus, with a pipelined read path.
// Define TMEM_ATOMIC_EN to build the atomic read-modify-write lock FSM and its error sources.
module tmem_bus #(
  parameter int unsigned DW      = 64,
  parameter int unsigned TW      = 8,
  parameter int unsigned AW      = 20,
  parameter int unsigned LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] i_ad,
  input  logic [TW-1:0] i_tag,
  input  logic          i_astb,
  input  logic          i_atomic,
  input  logic          i_rd,
  input  logic          i_wr,
  output logic [DW-1:0] o_data,
  output logic [TW-1:0] o_tag,
  output logic          o_valid,
  output logic          o_lock,
  output logic          o_err,
  output logic [AW-1:0] waddr
);

  localparam int unsigned DEPTH = 2**AW;
  localparam int unsigned EW    = DW + TW;

  logic [DW-1:0] mem [DEPTH];
  logic [TW-1:0] tag [DEPTH];

  logic          wr_do;
  logic          rd_do;
  logic          bus_err;
  logic          atom_err;
  logic          pipe_vld;
  logic [EW-1:0] pipe_ent;

  // An address strobe steals the cycle; a write beats a simultaneous read.
  assign wr_do   = i_wr & ~i_astb;
  assign rd_do   = i_rd & ~i_wr & ~i_astb;
  assign bus_err = (i_rd & i_wr) | (i_astb & (i_rd | i_wr));

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr <= '0;
    end else if (i_astb) begin
      waddr <= i_ad[AW-1:0];
    end
  end

  // Storage is never reset.
  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem[waddr] <= i_ad;
      tag[waddr] <= i_tag;
    end
  end

  if (LATENCY > 1) begin : g_pipe
    localparam int unsigned NS = LATENCY - 1;
    localparam int unsigned PW = NS * EW;

    logic [NS-1:0]         vld;
    logic [NS-1:0][EW-1:0] ent;

    // Entry 0 is the newest read; payload shifts freely, only valid bits are reset.
    always_ff @(posedge clk) begin
      ent <= PW'({ent, mem[waddr], tag[waddr]});
      if (reset) begin
        vld <= '0;
      end else begin
        vld <= NS'({vld, rd_do});
      end
    end

    assign pipe_vld = vld[NS-1];
    assign pipe_ent = ent[NS-1];
  end else begin : g_direct
    assign pipe_vld = rd_do;
    assign pipe_ent = {mem[waddr], tag[waddr]};
  end

  // Output stage holds the last returned word while no read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_tag   <= '0;
    end else begin
      o_valid <= pipe_vld;
      if (pipe_vld) begin
        {o_data, o_tag} <= pipe_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_err <= 1'b0;
    end else begin
      o_err <= bus_err | atom_err;
    end
  end

`ifdef TMEM_ATOMIC_EN
  typedef enum logic [1:0] {
    IDLE,
    LOCK_RD,
    LOCK_WR
  } state_t;

  state_t state;

  // A strobe inside a locked sequence aborts it; a write before the read breaks it.
  assign atom_err = ((state != IDLE) & i_astb) |
                    ((state == LOCK_RD) & i_wr & ~i_astb);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      o_lock <= 1'b0;
    end else if (i_astb) begin
      state  <= i_atomic ? LOCK_RD : IDLE;
      o_lock <= i_atomic;
    end else begin
      case (state)
        LOCK_RD: begin
          if (i_wr) begin
            state  <= IDLE;
            o_lock <= 1'b0;
          end else if (i_rd) begin
            state <= LOCK_WR;
          end
        end
        LOCK_WR: begin
          if (i_wr) begin
            state  <= IDLE;
            o_lock <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_lock <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused_atomic;

  assign unused_atomic = i_atomic;
  assign atom_err      = 1'b0;
  assign o_lock        = 1'b0;
`endif

endmodule

// File: tb/tb_tmem_bus.sv
// tb_tmem_bus: vector table plus read scoreboard for tmem_bus at LATENCY 1, 3 and 4.
`timescale 1ns/1ps
module tb_tmem_bus;

  localparam int unsigned DW = 64;
  localparam int unsigned TW = 8;
  localparam int unsigned AW = 20;
  localparam int NI = 3;
`ifdef TMEM_ATOMIC_EN
  localparam bit ATOMIC = 1'b1;
`else
  localparam bit ATOMIC = 1'b0;
`endif

  typedef struct {
    bit            rst, astb, atomic, rd, wr;
    logic [DW-1:0] ad;
    logic [TW-1:0] tg;
    bit            ea, eb, la;  // next-cycle err (atomic build / base build), lock (atomic build)
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    longint        due;
    longint        iss;
  } rd_t;

  logic clk, reset, astb, atomic, rd, wr;
  logic [DW-1:0] ad;
  logic [TW-1:0] tg;
  logic [DW-1:0] data  [NI];
  logic [TW-1:0] otag  [NI];
  logic          valid [NI];
  logic          lock  [NI];
  logic          err   [NI];
  logic [AW-1:0] waddr [NI];

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  bit rst_q = 1'b0;
  bit run = 1'b0;
  bit exp_v;

  logic [DW-1:0] mm [int];
  logic [TW-1:0] mt [int];
  logic [AW-1:0] maddr = '0;
  logic [AW-1:0] exp_wa = '0;
  rd_t sbq [NI][$];
  rd_t keep [$];
  logic [DW-1:0] last_d [NI];
  logic [TW-1:0] last_t [NI];
  vec_t tab [$];

  tmem_bus #(.DW(DW), .TW(TW), .AW(AW), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .i_ad(ad), .i_tag(tg), .i_astb(astb), .i_atomic(atomic),
    .i_rd(rd), .i_wr(wr), .o_data(data[0]), .o_tag(otag[0]), .o_valid(valid[0]),
    .o_lock(lock[0]), .o_err(err[0]), .waddr(waddr[0]));
  tmem_bus #(.DW(DW), .TW(TW), .AW(AW), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .i_ad(ad), .i_tag(tg), .i_astb(astb), .i_atomic(atomic),
    .i_rd(rd), .i_wr(wr), .o_data(data[1]), .o_tag(otag[1]), .o_valid(valid[1]),
    .o_lock(lock[1]), .o_err(err[1]), .waddr(waddr[1]));
  tmem_bus #(.DW(DW), .TW(TW), .AW(AW), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .i_ad(ad), .i_tag(tg), .i_astb(astb), .i_atomic(atomic),
    .i_rd(rd), .i_wr(wr), .o_data(data[2]), .o_tag(otag[2]), .o_valid(valid[2]),
    .o_lock(lock[2]), .o_err(err[2]), .waddr(waddr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic vec_t mkv(bit rst_i, bit astb_i, bit atomic_i, bit rd_i, bit wr_i,
                               logic [DW-1:0] ad_i, logic [TW-1:0] tg_i,
                               bit ea_i, bit eb_i, bit la_i);
    vec_t v;
    v.rst = rst_i; v.astb = astb_i; v.atomic = atomic_i; v.rd = rd_i; v.wr = wr_i;
    v.ad = ad_i; v.tg = tg_i; v.ea = ea_i; v.eb = eb_i; v.la = la_i;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Applies one cycle of stimulus and advances the reference memory/address model.
  task automatic drive(vec_t v);
    rd_t e;
    reset = v.rst; astb = v.astb; atomic = v.atomic; rd = v.rd; wr = v.wr;
    ad = v.ad; tg = v.tg;
    if (v.rst) begin
      maddr = '0;
    end else if (v.astb) begin
      maddr = v.ad[AW-1:0];
    end else if (v.wr) begin
      mm[int'(maddr)] = v.ad;
      mt[int'(maddr)] = v.tg;
    end else if (v.rd) begin
      for (int k = 0; k < NI; k++) begin
        e.d = mm[int'(maddr)];
        e.t = mt[int'(maddr)];
        e.due = cyc + longint'(lat_of(k));
        e.iss = cyc;
        sbq[k].push_back(e);
      end
    end
    exp_wa = maddr;
  endtask

  task automatic check_row(vec_t v, int idx);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("err row%0d L%0d", idx, lat_of(k)), 64'(err[k]), 64'(ATOMIC ? v.ea : v.eb));
      chk($sformatf("lock row%0d L%0d", idx, lat_of(k)), 64'(lock[k]), 64'(ATOMIC & v.la));
      chk($sformatf("waddr row%0d L%0d", idx, lat_of(k)), 64'(waddr[k]), 64'(exp_wa));
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_q = reset;
  end

  // Scoreboard: every cycle each instance must show exactly the reads due now, data held otherwise.
  initial forever begin
    @(negedge clk);
    if (run) begin
      for (int k = 0; k < NI; k++) begin
        if (rst_q) begin
          keep.delete();
          for (int j = 0; j < sbq[k].size(); j++)
            if (sbq[k][j].iss >= cyc) keep.push_back(sbq[k][j]);
          sbq[k] = keep;
          last_d[k] = '0;
          last_t[k] = '0;
        end
        exp_v = 1'b0;
        if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
          exp_v = 1'b1;
          last_d[k] = sbq[k][0].d;
          last_t[k] = sbq[k][0].t;
          void'(sbq[k].pop_front());
        end
        chk($sformatf("valid L%0d", lat_of(k)), 64'(valid[k]), 64'(exp_v));
        chk($sformatf("data L%0d", lat_of(k)), 64'(data[k]), 64'(last_d[k]));
        chk($sformatf("tag L%0d", lat_of(k)), 64'(otag[k]), 64'(last_t[k]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    idle = mkv(0,0,0,0,0, '0, '0, 0,0,0);
    reset = 1'b1; astb = 1'b0; atomic = 1'b0; rd = 1'b0; wr = 1'b0; ad = '0; tg = '0;

    // Basic write then read at 0x10.
    tab.push_back(mkv(1,0,0,0,0, '0, '0, 0,0,0));
    tab.push_back(mkv(0,1,0,0,0, 64'h10, '0, 0,0,0));
    tab.push_back(mkv(0,0,0,0,1, 64'h0123456789ABCDEF, 8'h35, 0,0,0));
    tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,0));
    for (int a = 1; a <= 3; a++) begin
      tab.push_back(mkv(0,1,0,0,0, 64'(a), '0, 0,0,0));
      tab.push_back(mkv(0,0,0,0,1, 64'hA5A5_0000_0000_0000 | 64'(a), 8'(8'h10 + a), 0,0,0));
    end
    tab.push_back(mkv(0,1,0,0,0, 64'hFFFFF, '0, 0,0,0));
    tab.push_back(mkv(0,0,0,0,1, 64'h77, 8'h07, 0,0,0));
    // Reads of 1,2,3 with strobes between, then three back-to-back reads.
    for (int a = 1; a <= 3; a++) begin
      tab.push_back(mkv(0,1,0,0,0, 64'(a), '0, 0,0,0));
      tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,0));
    end
    for (int n = 0; n < 3; n++) tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,0));
    // Atomic sequence at 0xFFFFF with upper address bits set.
    tab.push_back(mkv(0,1,1,0,0, '1, '0, 0,0,1));
    tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,1));
    tab.push_back(mkv(0,0,0,0,1, 64'h1, 8'h01, 0,0,0));
    tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,0));
    // Abort by a plain strobe to 0x2.
    tab.push_back(mkv(0,1,1,0,0, 64'h10, '0, 0,0,1));
    tab.push_back(mkv(0,1,0,0,0, 64'h2, '0, 1,0,0));
    // Re-arm abort, then read twice in LOCK_WR and finish.
    tab.push_back(mkv(0,1,1,0,0, 64'h2, '0, 0,0,1));
    tab.push_back(mkv(0,1,1,0,0, 64'h3, '0, 1,0,1));
    tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,1));
    tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,1));
    tab.push_back(mkv(0,0,0,0,1, 64'h99, 8'h09, 0,0,0));
    tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,0));
    // Write while waiting for the locked read.
    tab.push_back(mkv(0,1,1,0,0, 64'h1, '0, 0,0,1));
    tab.push_back(mkv(0,0,0,0,1, 64'h55, 8'h05, 1,0,0));
    tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,0));
    // rd+wr collision, then strobe collisions.
    tab.push_back(mkv(0,1,0,0,0, 64'h20, '0, 0,0,0));
    tab.push_back(mkv(0,0,0,1,1, 64'hAA, 8'h0A, 1,1,0));
    tab.push_back(mkv(0,0,0,0,0, '0, '0, 0,0,0));
    tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,0));
    tab.push_back(mkv(0,1,0,1,0, 64'h3, '0, 1,1,0));
    tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,0));
    tab.push_back(mkv(0,1,0,0,1, 64'h2, 8'h77, 1,1,0));
    tab.push_back(mkv(0,0,0,1,0, '0, '0, 0,0,0));

    @(posedge clk);
    run = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset err L%0d", lat_of(k)), 64'(err[k]), 64'(0));
      chk($sformatf("reset lock L%0d", lat_of(k)), 64'(lock[k]), 64'(0));
      chk($sformatf("reset waddr L%0d", lat_of(k)), 64'(waddr[k]), 64'(0));
    end

    for (int i = 0; i < tab.size(); i++) begin
      if (i > 0) begin
        @(negedge clk);
        check_row(tab[i-1], i-1);
      end
      drive(tab[i]);
    end
    @(negedge clk);
    check_row(tab[tab.size()-1], tab.size()-1);
    drive(idle);

    // Reset with two reads in flight through the deepest pipeline.
    @(negedge clk); drive(mkv(0,1,0,0,0, 64'h2, '0, 0,0,0));
    @(negedge clk); drive(mkv(0,0,0,1,0, '0, '0, 0,0,0));
    @(negedge clk); drive(mkv(0,0,0,1,0, '0, '0, 0,0,0));
    @(negedge clk); drive(mkv(1,0,0,0,0, '0, '0, 0,0,0));
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("post-reset valid L4", 64'(valid[2]), 64'(0));
      chk("post-reset data L4", 64'(data[2]), 64'(0));
      chk("post-reset tag L4", 64'(otag[2]), 64'(0));
      chk("post-reset waddr L4", 64'(waddr[2]), 64'(0));
      chk("post-reset lock L4", 64'(lock[2]), 64'(0));
      chk("post-reset err L4", 64'(err[2]), 64'(0));
      drive(idle);
    end
    @(negedge clk); drive(mkv(0,1,0,0,0, 64'h2, '0, 0,0,0));
    @(negedge clk); drive(mkv(0,0,0,1,0, '0, '0, 0,0,0));
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      drive(idle);
    end
    for (int k = 0; k < NI; k++)
      chk($sformatf("drained L%0d", lat_of(k)), 64'(sbq[k].size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
